// File: rtl/eth_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_pkt_gen
// Brief    : AXIS Ethernet TX frame generator (L2 header + seeded byte ramp).
// Revision : 1.0  initial release
// ============================================================================
module eth_tx_pkt_gen #(
  parameter int DATA_W     = 512,
  parameter int TUSER_W    = 1,
  parameter int IFG_CYCLES = 2,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [13:0]           cfg_len_i,
  input  logic [31:0]           cfg_num_pkts_i,
  input  logic [47:0]           cfg_dst_mac_i,
  input  logic [47:0]           cfg_src_mac_i,
  input  logic [15:0]           cfg_etype_i,
  input  logic                  tx_tready_i,
  output logic                  tx_tvalid_o,
  output logic                  tx_tlast_o,
  output logic [DATA_W-1:0]     tx_tdata_o,
  output logic [DATA_W/8-1:0]   tx_tkeep_o,
  output logic [TUSER_W-1:0]    tx_tuser_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           pkt_cnt_o,
  output logic [47:0]           byte_cnt_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [13:0]        len_q;
  logic [31:0]        num_q;
  logic [47:0]        dst_q;
  logic [47:0]        src_q;
  logic [15:0]        etype_q;
  logic               stop_seen_q;
  logic [GAP_W-1:0]   gap_q;
  logic [15:0]        beat_idx_q;
  logic [7:0]         seed_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic [DATA_W-1:0]  tdata_q;
  logic [BYTES-1:0]   tkeep_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        pkt_cnt_q;
  logic [47:0]        byte_cnt_q;

  logic [13:0]        len_clamp_d;
  logic [15:0]        beats_d;
  logic [15:0]        rem_d;
  logic [15:0]        last_bytes_d;
  logic [15:0]        idx_d;
  logic [7:0]         seed_d;
  logic [127:0]       hdr_d;
  logic               last_d;
  logic [BYTES-1:0]   keep_d;
  logic [DATA_W-1:0]  data_d;
  logic               acc_d;
  logic               stop_now_d;

  assign len_clamp_d  = (cfg_len_i < 14'(MIN_LEN)) ? 14'(MIN_LEN) :
                        (cfg_len_i > 14'(MAX_LEN)) ? 14'(MAX_LEN) : cfg_len_i;
  assign beats_d      = 16'((32'(len_q) + BYTES - 1) / BYTES);
  assign rem_d        = 16'(32'(len_q) % BYTES);
  assign last_bytes_d = (rem_d == 16'd0) ? 16'(BYTES) : rem_d;

  // The beat being prepared: beat 0 while loading, otherwise the one after the current.
  assign idx_d  = (state_q == S_LOAD) ? 16'd0 : beat_idx_q + 16'd1;
  assign seed_d = (state_q == S_LOAD) ? pkt_cnt_q[7:0] : seed_q;
  assign hdr_d  = {dst_q, src_q, etype_q, 16'h0000};
  assign last_d = (idx_d == beats_d - 16'd1);
  assign keep_d = (last_d && rem_d != 16'd0) ? ({BYTES{1'b1}} >> (BYTES - int'(rem_d)))
                                             : {BYTES{1'b1}};

  for (genvar k = 0; k < BYTES; k++) begin : g_byte
    logic [15:0] n;
    assign n = 16'(32'(idx_d) * BYTES + k);
    assign data_d[8*k +: 8] = (n < 16'd14) ? hdr_d[8*(15 - int'(n[3:0])) +: 8]
                                           : seed_d + n[7:0] - 8'd14;
  end

  assign acc_d      = tvalid_q & tx_tready_i;
  assign stop_now_d = stop_seen_q | stop_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      num_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      etype_q     <= '0;
      stop_seen_q <= 1'b0;
      gap_q       <= '0;
      beat_idx_q  <= '0;
      seed_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q       <= len_clamp_d;
            num_q       <= cfg_num_pkts_i;
            dst_q       <= cfg_dst_mac_i;
            src_q       <= cfg_src_mac_i;
            etype_q     <= cfg_etype_i;
            stop_seen_q <= stop_i;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          stop_seen_q <= stop_now_d;
          beat_idx_q  <= '0;
          seed_q      <= seed_d;
          tdata_q     <= data_d;
          tkeep_q     <= keep_d;
          tlast_q     <= last_d;
          tvalid_q    <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          stop_seen_q <= stop_now_d;
          if (acc_d) begin
            byte_cnt_q <= byte_cnt_q + (tlast_q ? 48'(last_bytes_d) : 48'(BYTES));
            if (tlast_q) begin
              tvalid_q  <= 1'b0;
              tlast_q   <= 1'b0;
              pkt_cnt_q <= pkt_cnt_q + 32'd1;
              if (stop_now_d || (num_q != 32'd0 && pkt_cnt_q + 32'd1 == num_q)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else if (IFG_CYCLES > 0) begin
                gap_q   <= GAP_W'(IFG_CYCLES - 1);
                state_q <= S_GAP;
              end else begin
                state_q <= S_LOAD;
              end
            end else begin
              beat_idx_q <= idx_d;
              tdata_q    <= data_d;
              tkeep_q    <= keep_d;
              tlast_q    <= last_d;
            end
          end
        end
        S_GAP: begin
          stop_seen_q <= stop_now_d;
          if (stop_now_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (gap_q == '0) begin
            state_q <= S_LOAD;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_tvalid_o = tvalid_q;
  assign tx_tlast_o  = tlast_q;
  assign tx_tdata_o  = tdata_q;
  assign tx_tkeep_o  = tkeep_q;
  assign tx_tuser_o  = '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign byte_cnt_o  = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_pkt_gen
// Brief    : Self-checking bench for eth_tx_pkt_gen (vector table + random runs).
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_tx_pkt_gen;

  localparam int DATA_W = 512;
  localparam int BYTES  = DATA_W / 8;
  localparam int IFG    = 2;
  localparam int LIMIT  = 20000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic [13:0]       cfg_len_i = '0;
  logic [31:0]       cfg_num_pkts_i = '0;
  logic [47:0]       cfg_dst_mac_i = '0;
  logic [47:0]       cfg_src_mac_i = '0;
  logic [15:0]       cfg_etype_i = '0;
  logic              tx_tready_i = 1'b0;
  logic              tx_tvalid_o;
  logic              tx_tlast_o;
  logic [DATA_W-1:0] tx_tdata_o;
  logic [BYTES-1:0]  tx_tkeep_o;
  logic [0:0]        tx_tuser_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       pkt_cnt_o;
  logic [47:0]       byte_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int pct    = 100;

  always #5 clk = ~clk;

  eth_tx_pkt_gen #(
    .DATA_W(DATA_W), .TUSER_W(1), .IFG_CYCLES(IFG), .MIN_LEN(64), .MAX_LEN(9600)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .cfg_len_i(cfg_len_i), .cfg_num_pkts_i(cfg_num_pkts_i),
    .cfg_dst_mac_i(cfg_dst_mac_i), .cfg_src_mac_i(cfg_src_mac_i), .cfg_etype_i(cfg_etype_i),
    .tx_tready_i(tx_tready_i), .tx_tvalid_o(tx_tvalid_o), .tx_tlast_o(tx_tlast_o),
    .tx_tdata_o(tx_tdata_o), .tx_tkeep_o(tx_tkeep_o), .tx_tuser_o(tx_tuser_o),
    .busy_o(busy_o), .done_o(done_o), .pkt_cnt_o(pkt_cnt_o), .byte_cnt_o(byte_cnt_o)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  keep;
    logic              last;
    int                gap;
  } beat_t;

  typedef struct {
    int          len;
    int          num;
    int          pct;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    int          beats;
    logic [63:0] lkeep;
    int          pkts;
    longint      bytes;
  } vec_t;

  beat_t mon_q[$];
  beat_t held;
  beat_t mb;
  logic  stall = 1'b0;
  logic  new_frame = 1'b1;
  int    idle_run = 0;
  int    frames_seen = 0;
  int    beats_in_frame = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Bus monitor: sampled mid-cycle, so what it sees is what the next rising edge acts on.
  always @(negedge clk) begin : mon
    if (rst) begin
      stall = 1'b0;
      new_frame = 1'b1;
      idle_run = 0;
      beats_in_frame = 0;
    end else begin
      if (done_o) done_cnt++;
      if (stall)
        check("hold_while_stalled",
              {63'd0, tx_tvalid_o && tx_tlast_o == held.last &&
                      tx_tkeep_o == held.keep && tx_tdata_o == held.data}, 64'd1);
      if (tx_tvalid_o) begin
        mb.data = tx_tdata_o;
        mb.keep = tx_tkeep_o;
        mb.last = tx_tlast_o;
        mb.gap  = new_frame ? idle_run : 0;
        if (tx_tready_i) begin
          mon_q.push_back(mb);
          stall = 1'b0;
          idle_run = 0;
          new_frame = mb.last;
          if (mb.last) begin
            frames_seen++;
            beats_in_frame = 0;
          end else begin
            beats_in_frame++;
          end
        end else begin
          stall = 1'b1;
          held = mb;
        end
      end else begin
        idle_run++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_tready_i = ($urandom_range(99) < pct);
  endtask

  function automatic int clampl(int l);
    return (l < 64) ? 64 : ((l > 9600) ? 9600 : l);
  endfunction

  // Reference frame content: byte n of a frame, straight from the frame layout rules.
  function automatic logic [7:0] mbyte(logic [47:0] d, logic [47:0] s, logic [15:0] e,
                                       int seed, int n);
    if (n < 6)   return d[8*(5-n) +: 8];
    if (n < 12)  return s[8*(11-n) +: 8];
    if (n == 12) return e[15:8];
    if (n == 13) return e[7:0];
    return 8'((seed + n - 14) % 256);
  endfunction

  task automatic start_run(input int len, input int num, input logic [47:0] d,
                           input logic [47:0] s, input logic [15:0] e, input logic with_stop);
    mon_q.delete();
    done_cnt = 0;
    frames_seen = 0;
    cfg_len_i = 14'(len);
    cfg_num_pkts_i = num;
    cfg_dst_mac_i = d;
    cfg_src_mac_i = s;
    cfg_etype_i = e;
    start_i = 1'b1;
    stop_i = with_stop;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    check("no_valid_in_load", {63'd0, tx_tvalid_o}, 64'd0);
    tick();
    check("valid_2clk_after_start", {63'd0, tx_tvalid_o}, 64'd1);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (done_o !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("done_within_budget", {63'd0, cyc < LIMIT}, 64'd1);
    check("busy_low_at_done", {63'd0, busy_o}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done_o}, 64'd0);
    repeat (3) tick();
    check("done_pulse_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic verify(input int len, input int nfr, input logic [47:0] d, input logic [47:0] s,
                        input logic [15:0] e, input int exp_beats, input logic [63:0] exp_lkeep);
    int L = clampl(len);
    for (int f = 0; f < nfr; f++) begin
      int nb = 0;
      int bad = 0;
      int gap = 0;
      logic [63:0] lk = '0;
      logic got_last = 1'b0;
      while (!got_last && mon_q.size() > 0 && nb < 200) begin
        beat_t b = mon_q.pop_front();
        logic [63:0] ek = (nb == exp_beats - 1) ? exp_lkeep : '1;
        if (nb == 0) gap = b.gap;
        for (int k = 0; k < BYTES; k++) begin
          int n = nb * BYTES + k;
          if (n < L && b.data[8*k +: 8] !== mbyte(d, s, e, f % 256, n)) bad++;
        end
        if (64'(b.keep) !== ek) bad++;
        lk = 64'(b.keep);
        got_last = b.last;
        nb++;
      end
      check($sformatf("frame%0d_beats", f), 64'(nb), 64'(exp_beats));
      check($sformatf("frame%0d_last_keep", f), lk, exp_lkeep);
      check($sformatf("frame%0d_bad_bytes", f), 64'(bad), 64'd0);
      // GAP cycles plus the LOAD cycle separate consecutive frames.
      if (f > 0) check($sformatf("frame%0d_idle_gap", f), 64'(gap), 64'(IFG + 1));
    end
    check("no_extra_beats", 64'(mon_q.size()), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    pct = v.pct;
    start_run(v.len, v.num, v.dst, v.src, v.et, 1'b0);
    wait_done();
    check("pkt_cnt", 64'(pkt_cnt_o), 64'(v.pkts));
    check("byte_cnt", 64'(byte_cnt_o), 64'(v.bytes));
    verify(v.len, v.pkts, v.dst, v.src, v.et, v.beats, v.lkeep);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t rv;
    int cyc;
    tbl[0] = '{64,    1,  100, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 1,   '1,            1,  64};
    tbl[1] = '{130,   3,  100, 48'h020000000001, 48'h020000000002, 16'h88B5, 3,   64'h3,         3,  390};
    tbl[2] = '{1500,  10, 50,  48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0806, 24,  64'h0FFF_FFFF, 10, 15000};
    tbl[3] = '{20,    2,  100, 48'hFFFFFFFFFFFF, 48'h123456789ABC, 16'h86DD, 1,   '1,            2,  128};
    tbl[4] = '{16000, 1,  70,  48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0800, 150, '1,            1,  9600};
    tbl[5] = '{65,    2,  80,  48'h000000000001, 48'h000000000002, 16'h1234, 2,   64'h1,         2,  130};

    pct = 100;
    repeat (3) tick();
    check("rst_tvalid", {63'd0, tx_tvalid_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt_o), 64'd0);
    check("rst_tkeep", 64'(tx_tkeep_o), 64'd0);
    check("rst_tdata_zero", {63'd0, tx_tdata_o == '0}, 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    check("tuser_zero", 64'(tx_tuser_o), 64'd0);

    for (int i = 0; i < 5; i++) begin
      int L;
      int r;
      rv.len = $urandom_range(2100, 10);
      rv.num = $urandom_range(4, 1);
      rv.pct = $urandom_range(100, 30);
      rv.dst = {$urandom, $urandom};
      rv.src = {$urandom, $urandom};
      rv.et  = 16'($urandom);
      L = clampl(rv.len);
      r = L % BYTES;
      rv.beats = (L + BYTES - 1) / BYTES;
      rv.lkeep = (r == 0) ? '1 : ((64'd1 << r) - 64'd1);
      rv.pkts  = rv.num;
      rv.bytes = longint'(rv.num) * L;
      run_vec(rv);
    end

    // Continuous run stopped during the fifth frame.
    pct = 100;
    start_run(130, 0, 48'h111111111111, 48'h222222222222, 16'h0800, 1'b0);
    cyc = 0;
    while (!(frames_seen == 4 && beats_in_frame >= 1) && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("reach_frame5", {63'd0, cyc < LIMIT}, 64'd1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done();
    check("stop_pkt_cnt", 64'(pkt_cnt_o), 64'd5);
    check("stop_byte_cnt", 64'(byte_cnt_o), 64'd650);
    verify(130, 5, 48'h111111111111, 48'h222222222222, 16'h0800, 3, 64'h3);

    // start and stop together while idle: exactly one frame.
    start_run(64, 0, 48'h333333333333, 48'h444444444444, 16'h0800, 1'b1);
    wait_done();
    check("startstop_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
    check("startstop_byte_cnt", 64'(byte_cnt_o), 64'd64);
    verify(64, 1, 48'h333333333333, 48'h444444444444, 16'h0800, 1, '1);

    // start pulsed mid-run with different config must be ignored.
    start_run(130, 3, 48'h555555555555, 48'h666666666666, 16'h0801, 1'b0);
    repeat (4) tick();
    cfg_len_i = 14'd64;
    cfg_num_pkts_i = 32'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done();
    check("busy_start_pkt_cnt", 64'(pkt_cnt_o), 64'd3);
    check("busy_start_byte_cnt", 64'(byte_cnt_o), 64'd390);
    verify(130, 3, 48'h555555555555, 48'h666666666666, 16'h0801, 3, 64'h3);

    // Reset during beat 2 of a 3-beat frame, then a clean restart.
    start_run(130, 1, 48'h777777777777, 48'h888888888888, 16'h0800, 1'b0);
    cyc = 0;
    while (beats_in_frame != 1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("reach_beat2", {63'd0, cyc < LIMIT}, 64'd1);
    rst = 1'b1;
    tx_tready_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tvalid", {63'd0, tx_tvalid_o}, 64'd0);
    check("midrst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    check("midrst_byte_cnt", 64'(byte_cnt_o), 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    rst = 1'b0;
    tick();
    tick();
    start_run(64, 1, 48'h999999999999, 48'hABABABABABAB, 16'h0800, 1'b0);
    wait_done();
    check("post_rst_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
    verify(64, 1, 48'h999999999999, 48'hABABABABABAB, 16'h0800, 1, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
